mult_scheduler: RTL and testbench
=================================

Name: mult_scheduler

Overview:
- Shares one shift-add multiplier core (start/Ready handshake, 2*DP_WIDTH-bit product) among N_REQ requesters.
- Round-robin arbitration; operands latched at grant; start pulse issued to the core; product captured in the single cycle it is valid; result returned with a per-requester done pulse.
- Includes a watchdog that flags a hung core.

Parameters:
- DP_WIDTH, 5, operand width; must match the multiplier core.
- N_REQ, 4, number of requesters (2..8).
- TMO_CYCLES, 2*DP_WIDTH+4, maximum WAIT_DONE cycles before the error flag is raised.

Ports:
- clock  in  1  clock.
- reset_b  in  1  async active-low reset.
- req  in  N_REQ  per-requester request level; hold with operands stable until ack.
- op_a  in  N_REQ*DP_WIDTH  flattened multiplicands; slice i belongs to requester i.
- op_b  in  N_REQ*DP_WIDTH  flattened multipliers.
- ack  out  N_REQ  one-cycle grant pulse; operands captured.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- result  out  2*DP_WIDTH  product; valid while any done bit is high, holds last value otherwise.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky watchdog error; cleared only by reset.
- mul_start  out  1  start to the core.
- mul_multiplicand  out  DP_WIDTH  to the core.
- mul_multiplier  out  DP_WIDTH  to the core.
- mul_product  in  2*DP_WIDTH  from the core.
- mul_ready  in  1  core Ready (high only in the core idle state).

Behaviour:
- Reset and clock: reset_b asynchronous, active-low; clock clock. Reset clears every register.
- Reset values: state=IDLE; ack=0, done=0, result=0, busy=0, err=0, mul_start=0, operand regs=0; RR pointer gives requester 0 top priority.
- Core contract:
  - The core reloads its registers on every clock edge spent in its idle state, so the product is valid only in the first cycle mul_ready returns high.
  - Core sequence after start = 2*DP_WIDTH cycles with mul_ready=0.
- States (one-hot): IDLE, ISSUE, WAIT_DONE, DELIVER.
- IDLE:
  - If any req is high and mul_ready=1, choose g = first requester with req high, searching upward from (last_grant+1) mod N_REQ.
  - At that edge: latch op_a[g], op_b[g] into the operand regs; owner<=g; last_grant<=g; ack[g]<=1 for one cycle; go to ISSUE.
  - If mul_ready=0, stay in IDLE and grant nothing.
- ISSUE:
  - mul_start = (state==ISSUE) & mul_ready, combinational.
  - Go to WAIT_DONE on the edge where mul_start=1; otherwise hold.
- WAIT_DONE:
  - Timeout counter increments each cycle.
  - On the first cycle with mul_ready=1: result<=mul_product; go to DELIVER.
  - If the counter reaches TMO_CYCLES first: err<=1; go to IDLE; no done.
- DELIVER: done[owner]=1 for exactly one cycle; result stable; go to IDLE.
- Latency (DP_WIDTH=5): req seen in cycle 0 -> ack in cycle 1 -> mul_start in cycle 1 -> product captured in cycle 12 -> done in cycle 13. Back-to-back throughput is one product per 14 cycles.
- mul_multiplicand/mul_multiplier are driven from the latched regs at all times; they never change while busy=1.
- Arbitration runs only in IDLE. A req held through ack is not re-granted before that op's DELIVER, and after DELIVER it competes under round-robin as a new request.
- A req dropped before ack is withdrawn with no side effects. req changes while busy are ignored.
- Simultaneous requests: exactly one ack per grant. Pointer rotation guarantees every persistent requester is served within N_REQ grants.
- Reset mid-operation: scheduler and core reset together. No done is issued for the aborted operation; after release the scheduler sits in IDLE with no pending grant.
- Product width: 2*DP_WIDTH bits, unsigned; no truncation.

Decomposition:
- Shared package mult_sched_pkg holds:
  - state one-hot encodings (S_IDLE=4'b0001, S_ISSUE=4'b0010, S_WAIT=4'b0100, S_DELIV=4'b1000);
  - DP_WIDTH default;
  - MUL_LATENCY = 2*DP_WIDTH;
  - the TMO_CYCLES formula.
- One sub-module, rr_arbiter: purely combinational. Inputs req and last_grant; outputs one-hot grant plus encoded index.

Test Plan:
- Single request: req[2]=1, op_a[2]=13, op_b[2]=11 -> ack[2] in cycle 1, done[2] in cycle 13, result=143.
- Full contention: all req high, operands i+3 and i+1 -> grant order 0,1,2,3,0; each result=(i+3)*(i+1); one ack per grant.
- Max operands: 31*31 -> result=961 (10'h3C1). Also 0*31 -> result=0, done still issued at cycle 13.
- Withdraw: req[1] pulsed for one cycle while busy, then dropped -> no ack[1], no done[1]; pointer unchanged.
- Hung core: model holds mul_ready=0 after start -> err=1 after TMO_CYCLES=14 WAIT_DONE cycles; state returns to IDLE; no done.
- Reset mid-operation: reset_b low for 2 cycles in WAIT_DONE -> all outputs 0; requester 0 has top priority afterwards; a new request completes normally.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the multiplier scheduler.
package mult_sched_pkg;

  localparam int unsigned DP_WIDTH_DEF = 5;
  localparam int unsigned MUL_LATENCY  = 2 * DP_WIDTH_DEF;

  // One-hot scheduler states
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_DELIV = 4'b1000
  } state_t;

  // Watchdog limit: core latency plus a small margin
  function automatic int unsigned tmo_cycles(input int unsigned dp_width);
    return 2 * dp_width + 4;
  endfunction

endpackage

// File: rtl/mult_scheduler_if.sv
// Requester-side bus of the multiplier scheduler.
interface mult_scheduler_if import mult_sched_pkg::*; #(
  parameter int unsigned DP_WIDTH = DP_WIDTH_DEF,
  parameter int unsigned N_REQ    = 4
);

  logic [N_REQ-1:0]          req;
  logic [N_REQ*DP_WIDTH-1:0] op_a;
  logic [N_REQ*DP_WIDTH-1:0] op_b;
  logic [N_REQ-1:0]          ack;
  logic [N_REQ-1:0]          done;
  logic [2*DP_WIDTH-1:0]     result;

  modport master (output req, op_a, op_b, input ack, done, result);
  modport slave  (input req, op_a, op_b, output ack, done, result);

endinterface

// File: rtl/mult_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [N_REQ-1:0]         grant_c,
  output logic [$clog2(N_REQ)-1:0] grant_idx_c,
  output logic                     grant_vld_c
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  int unsigned j;

  // First requester above the last grant wins, wrapping around
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    grant_vld_c = 1'b0;
    j           = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      j = (32'(last_grant) + k) % N_REQ;
      if (!grant_vld_c && req[IDX_W'(j)]) begin
        grant_vld_c         = 1'b1;
        grant_idx_c         = IDX_W'(j);
        grant_c[IDX_W'(j)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one shift-add multiplier core among N_REQ round-robin requesters.
module mult_scheduler import mult_sched_pkg::*; #(
  parameter int unsigned DP_WIDTH   = DP_WIDTH_DEF,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned TMO_CYCLES = tmo_cycles(DP_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset_b,
  mult_scheduler_if.slave       rq,
  output logic                  busy,
  output logic                  err,
  output logic                  mul_start,
  output logic [DP_WIDTH-1:0]   mul_multiplicand,
  output logic [DP_WIDTH-1:0]   mul_multiplier,
  input  logic [2*DP_WIDTH-1:0] mul_product,
  input  logic                  mul_ready
);

  localparam int unsigned PW    = 2 * DP_WIDTH;
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TMO_CYCLES + 1);

  state_t               state_q, state_d;
  logic [DP_WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [IDX_W-1:0]     owner_q, owner_d, last_q, last_d;
  logic [N_REQ-1:0]     ack_q, ack_d, done_q, done_d;
  logic [PW-1:0]        result_q, result_d;
  logic                 busy_q, busy_d, err_q, err_d;
  logic [CNT_W-1:0]     tmo_q, tmo_d;

  logic [N_REQ-1:0]     grant_c;
  logic [IDX_W-1:0]     grant_idx_c;
  logic                 grant_vld_c;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req         (rq.req),
    .last_grant  (last_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .grant_vld_c (grant_vld_c)
  );

  // Start is only meaningful while the core sits idle
  assign mul_start = (state_q == S_ISSUE) && mul_ready;

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    owner_d  = owner_q;
    last_d   = last_q;
    ack_d    = '0;
    done_d   = '0;
    result_d = result_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld_c && mul_ready) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_idx_c == IDX_W'(i)) begin
              opa_d = rq.op_a[i*DP_WIDTH +: DP_WIDTH];
              opb_d = rq.op_b[i*DP_WIDTH +: DP_WIDTH];
            end
          end
          owner_d = grant_idx_c;
          last_d  = grant_idx_c;
          ack_d   = grant_c;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mul_start) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mul_ready) begin
          result_d        = mul_product;
          done_d          = '0;
          done_d[owner_q] = 1'b1;
          state_d         = S_DELIV;
        end else if (tmo_q == CNT_W'(TMO_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      S_DELIV: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      owner_q  <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      ack_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign rq.ack           = ack_q;
  assign rq.done          = done_q;
  assign rq.result        = result_q;
  assign busy             = busy_q;
  assign err              = err_q;
  assign mul_multiplicand = opa_q;
  assign mul_multiplier   = opb_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed self-checking bench for mult_scheduler with a behavioural core.
module tb_mult_scheduler;
  import mult_sched_pkg::*;

  localparam int unsigned DP  = 5;
  localparam int unsigned N   = 4;
  localparam int unsigned PW  = 2 * DP;
  localparam int unsigned TMO = 14;

  logic          clock;
  logic          reset_b;
  logic          busy, err, mul_start, mul_ready;
  logic [DP-1:0] mul_multiplicand, mul_multiplier;
  logic [PW-1:0] mul_product;
  logic          hang;

  int n_tests = 0;
  int n_fail  = 0;

  mult_scheduler_if #(.DP_WIDTH(DP), .N_REQ(N)) rq ();

  mult_scheduler #(.DP_WIDTH(DP), .N_REQ(N), .TMO_CYCLES(TMO)) dut (
    .clock            (clock),
    .reset_b          (reset_b),
    .rq               (rq),
    .busy             (busy),
    .err              (err),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product),
    .mul_ready        (mul_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Core model: idle reloads (product cleared), 2*DP busy cycles, product valid one cycle
  logic          core_busy;
  int unsigned   core_cnt;
  logic [PW-1:0] core_a, core_b;
  assign mul_ready = !core_busy;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      core_busy   <= 1'b0;
      core_cnt    <= 0;
      core_a      <= '0;
      core_b      <= '0;
      mul_product <= '0;
    end else if (!core_busy) begin
      if (mul_start) begin
        core_busy   <= 1'b1;
        core_cnt    <= 2 * DP;
        core_a      <= PW'(mul_multiplicand);
        core_b      <= PW'(mul_multiplier);
        mul_product <= PW'(10'h155);
      end else begin
        mul_product <= '0;
      end
    end else if (!hang) begin
      if (core_cnt == 1) begin
        core_busy   <= 1'b0;
        mul_product <= core_a * core_b;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [DP-1:0] a, input logic [DP-1:0] b);
    rq.op_a[i*DP +: DP] = a;
    rq.op_b[i*DP +: DP] = b;
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    step(2);
    reset_b = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    n_tests++;
    if ({rq.ack, rq.done, busy, err, mul_start} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ack=%b done=%b busy=%b err=%b start=%b, want all 0",
               rq.ack, rq.done, busy, err, mul_start);
    end
    n_tests++;
    if ({rq.result, mul_multiplicand, mul_multiplier} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: result=%0d mcand=%0d mplier=%0d, want 0",
               rq.result, mul_multiplicand, mul_multiplier);
    end
  endtask

  task automatic test_single();
    logic early;
    set_op(2, 5'd13, 5'd11);
    rq.req = 4'b0100;
    step(1);
    n_tests++;
    if (rq.ack !== 4'b0100 || mul_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ack: ack=%b start=%b busy=%b, want 0100 1 1", rq.ack, mul_start, busy);
    end
    n_tests++;
    if (mul_multiplicand !== 5'd13 || mul_multiplier !== 5'd11) begin
      n_fail++;
      $display("FAIL single_ops: mcand=%0d mplier=%0d, want 13 11", mul_multiplicand, mul_multiplier);
    end
    rq.req = 4'b0000;
    early = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      step(1);
      if (rq.done !== 4'b0000 || rq.ack !== 4'b0000) early = 1'b1;
    end
    n_tests++;
    if (early) begin
      n_fail++;
      $display("FAIL single_early: ack/done seen in cycles 2..12, want none");
    end
    step(1);
    n_tests++;
    if (rq.done !== 4'b0100 || rq.result !== PW'(143)) begin
      n_fail++;
      $display("FAIL single_done: done=%b result=%0d, want 0100 143", rq.done, rq.result);
    end
    step(1);
    n_tests++;
    if (rq.done !== 4'b0000 || rq.result !== PW'(143) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: done=%b result=%0d busy=%b, want 0000 143 0",
               rq.done, rq.result, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]  exp_oh;
    logic [PW-1:0] exp_res;
    int            idx;
    do_reset();
    for (int i = 0; i < int'(N); i++) set_op(i, DP'(i + 3), DP'(i + 1));
    rq.req = 4'b1111;
    step(1);
    for (int k = 0; k < 5; k++) begin
      idx            = k % int'(N);
      exp_oh         = '0;
      exp_oh[idx]    = 1'b1;
      exp_res        = PW'((idx + 3) * (idx + 1));
      n_tests++;
      if (rq.ack !== exp_oh) begin
        n_fail++;
        $display("FAIL rr_ack%0d: ack=%b, want %b", k, rq.ack, exp_oh);
      end
      step(12);
      n_tests++;
      if (rq.done !== exp_oh || rq.result !== exp_res || rq.ack !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_done%0d: done=%b result=%0d ack=%b, want %b %0d 0000",
                 k, rq.done, rq.result, rq.ack, exp_oh, exp_res);
      end
      if (k == 4) rq.req = 4'b0000;
      step(2);
    end
  endtask

  task automatic test_max_operands();
    set_op(3, 5'd31, 5'd31);
    rq.req = 4'b1000;
    step(1);
    rq.req = 4'b0000;
    n_tests++;
    if (rq.ack !== 4'b1000) begin
      n_fail++;
      $display("FAIL max_ack: ack=%b, want 1000", rq.ack);
    end
    step(12);
    n_tests++;
    if (rq.done !== 4'b1000 || rq.result !== 10'h3C1) begin
      n_fail++;
      $display("FAIL max_done: done=%b result=%h, want 1000 3c1", rq.done, rq.result);
    end
    step(1);
    set_op(1, 5'd0, 5'd31);
    rq.req = 4'b0010;
    step(1);
    rq.req = 4'b0000;
    step(12);
    n_tests++;
    if (rq.done !== 4'b0010 || rq.result !== PW'(0)) begin
      n_fail++;
      $display("FAIL zero_done: done=%b result=%0d, want 0010 0", rq.done, rq.result);
    end
    step(1);
  endtask

  task automatic test_withdraw();
    logic bad;
    set_op(0, 5'd2, 5'd3);
    set_op(1, 5'd7, 5'd9);
    set_op(2, 5'd1, 5'd1);
    rq.req = 4'b0001;
    step(1);
    rq.req = 4'b0000;
    step(2);
    rq.req = 4'b0010;
    step(1);
    rq.req = 4'b0000;
    bad = 1'b0;
    for (int c = 4; c <= 12; c++) begin
      if (rq.ack !== 4'b0000 || rq.done !== 4'b0000) bad = 1'b1;
      step(1);
    end
    n_tests++;
    if (bad || rq.done !== 4'b0001 || rq.result !== PW'(6)) begin
      n_fail++;
      $display("FAIL withdraw_done: done=%b result=%0d stray=%b, want 0001 6 0",
               rq.done, rq.result, bad);
    end
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      if (rq.ack !== 4'b0000 || rq.done !== 4'b0000 || busy !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL withdraw_idle: stray activity after withdrawn request, want none");
    end
    rq.req = 4'b0011;
    step(1);
    rq.req = 4'b0000;
    n_tests++;
    if (rq.ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL withdraw_ptr: ack=%b, want 0010", rq.ack);
    end
    step(12);
    n_tests++;
    if (rq.done !== 4'b0010 || rq.result !== PW'(63)) begin
      n_fail++;
      $display("FAIL withdraw_next: done=%b result=%0d, want 0010 63", rq.done, rq.result);
    end
    step(1);
  endtask

  task automatic test_hang();
    logic bad;
    hang = 1'b1;
    set_op(2, 5'd4, 5'd5);
    rq.req = 4'b0100;
    step(1);
    rq.req = 4'b0000;
    bad = 1'b0;
    for (int c = 2; c <= 15; c++) begin
      step(1);
      if (err !== 1'b0 || rq.done !== 4'b0000 || busy !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL hang_early: err/done/busy wrong during wait, want err=0 done=0 busy=1");
    end
    step(1);
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0 || rq.done !== 4'b0000) begin
      n_fail++;
      $display("FAIL hang_err: err=%b busy=%b done=%b, want 1 0 0000", err, busy, rq.done);
    end
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (err !== 1'b1 || rq.done !== 4'b0000) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL hang_sticky: err dropped or done issued, want err=1 done=0");
    end
    hang = 1'b0;
    do_reset();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL hang_clear: err=%b after reset, want 0", err);
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    set_op(1, 5'd9, 5'd7);
    rq.req = 4'b0010;
    step(1);
    rq.req = 4'b0000;
    step(4);
    reset_b = 1'b0;
    #1;
    n_tests++;
    if ({rq.ack, rq.done, busy, err, mul_start, rq.result, mul_multiplicand, mul_multiplier} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_out: ack=%b done=%b busy=%b result=%0d mcand=%0d, want 0",
               rq.ack, rq.done, busy, rq.result, mul_multiplicand);
    end
    step(2);
    reset_b = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      if (rq.ack !== 4'b0000 || rq.done !== 4'b0000 || busy !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL rstmid_quiet: activity after reset release, want none");
    end
    set_op(0, 5'd10, 5'd12);
    set_op(3, 5'd1, 5'd1);
    rq.req = 4'b1001;
    step(1);
    rq.req = 4'b0000;
    n_tests++;
    if (rq.ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_prio: ack=%b, want 0001", rq.ack);
    end
    step(12);
    n_tests++;
    if (rq.done !== 4'b0001 || rq.result !== PW'(120)) begin
      n_fail++;
      $display("FAIL rstmid_done: done=%b result=%0d, want 0001 120", rq.done, rq.result);
    end
    step(1);
  endtask

  initial begin
    reset_b = 1'b0;
    hang    = 1'b0;
    rq.req  = '0;
    rq.op_a = '0;
    rq.op_b = '0;
    #1;
    test_reset();
    step(2);
    reset_b = 1'b1;
    step(1);
    test_single();
    test_back_to_back();
    test_max_operands();
    test_withdraw();
    test_hang();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
